icache_refill: RTL
==================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameter: LINE_WIDTH, 128, bits per cache line (four 32-bit words).
REQ-002 Parameter: TIMEOUT, 255, max cycles waiting for a single memory response before abort.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: miss_valid  input  1  cache requests a line fill.
REQ-006 Port: miss_pc  input  32  PC that missed; line base = {miss_pc[31:4],4'b0000}.
REQ-007 Port: miss_ready  output  1  refill unit can accept a miss (IDLE only).
REQ-008 Port: mem_req  output  1  word read request to instruction memory.
REQ-009 Port: mem_addr  output  32  word address of current request, bits [1:0] = 0.
REQ-010 Port: mem_gnt  input  1  memory accepted mem_req this cycle.
REQ-011 Port: mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 Port: mem_rdata  input  32  returned instruction word.
REQ-013 Port: line_valid  output  1  one-cycle pulse: line_data/line_pc complete.
REQ-014 Port: line_data  output  LINE_WIDTH  assembled line; word k (addr base+4k) in bits [127-32k : 96-32k].
REQ-015 Port: line_pc  output  32  latched miss_pc for the delivered line (cache uses [31:9] tag, [8:4] index).
REQ-016 Port: err  output  1  one-cycle pulse: fill aborted on timeout.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, DONE, encoded in a 2-bit state register.
REQ-018 IDLE: miss_ready=1; miss_valid=1 SHALL latch miss_pc, clear word counter and timeout counter, go to REQ next cycle.
REQ-019 REQ: mem_req=1, mem_addr=base+4*cnt held stable until mem_gnt=1; on gnt go to WAIT.
REQ-020 WAIT: mem_req=0; on mem_rvalid=1 write mem_rdata into word slot cnt; if cnt==3 go to DONE, else cnt+1 and go to REQ.
REQ-021 Word counter SHALL be 2 bits, sequential 0..3, no wrap beyond one line; one outstanding request at most.
REQ-022 DONE: line_valid=1 for exactly one cycle with line_data/line_pc stable; next state IDLE.
REQ-023 line_data and line_pc SHALL hold their last values until the next fill writes them.
REQ-024 miss_valid outside IDLE SHALL be ignored (miss_ready=0); no queuing.
REQ-025 mem_rvalid in IDLE/REQ/DONE SHALL be ignored; mem_gnt outside REQ SHALL be ignored.
REQ-026 Timeout counter SHALL clear on entering WAIT, increment each WAIT cycle without rvalid; reaching TIMEOUT SHALL pulse err one cycle, go to IDLE, not pulse line_valid.
REQ-027 mem_gnt and mem_rvalid asserted in the same REQ cycle: only gnt honoured, data taken from the later WAIT rvalid.
REQ-028 Fill latency with gnt and rvalid immediate: 9 cycles from miss accept edge to line_valid (IDLE->REQ then 4x(REQ,WAIT)->DONE).

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, miss_ready=1, mem_req=0, line_valid=0, err=0, counters 0, line_data=0, line_pc=0.
REQ-030 Reset mid-fill SHALL abandon the fill; no line_valid for it; late mem_rvalid after reset ignored.

Structure
REQ-031 Shared package SHALL hold state encoding, LINE_WIDTH, WORDS_PER_LINE=4, and offset/index/tag bit-range constants common with the cache.
REQ-032 One sub-module, refill_timer (loadable saturating counter with expiry flag), SHALL implement the timeout.

Verification
REQ-033 miss_pc=0x0000_1234, gnt/rvalid immediate, rdata 0xA0,0xA1,0xA2,0xA3 -> mem_addr 0x1230,0x1234,0x1238,0x123C; line_data={A0,A1,A2,A3}; line_valid 9 cycles after accept; line_pc=0x1234.
REQ-034 Grant delayed 3 cycles per word -> mem_addr/mem_req stable while waiting; line identical to REQ-033.
REQ-035 miss_valid held high during fill with miss_pc=0xFFFF_FFF0 -> ignored; only one line_valid, then new fill starts from IDLE.
REQ-036 rvalid never returned, TIMEOUT=8 -> err pulse after 8 WAIT cycles, line_valid never, state IDLE, miss_ready=1.
REQ-037 rst asserted in WAIT of word 2 -> outputs at reset values immediately; subsequent rvalid ignored; next miss fills correctly.
REQ-038 Back-to-back misses 0x0000_0200 then 0x0000_0400 -> two line_valid pulses, distinct line_pc, no data bleed.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache line refill unit and the cache
// that consumes its lines: state encoding, line geometry and address fields.
package icache_refill_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned LINE_WIDTH     = 128;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned CNT_WIDTH      = 2;

  // Address fields shared with the cache (byte offset, set index, tag)
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned OFFSET_MSB = 3;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned INDEX_MSB  = 8;
  localparam int unsigned TAG_LSB    = 9;
  localparam int unsigned TAG_MSB    = 31;

  localparam int unsigned LINE_ADDR_WIDTH = ADDR_WIDTH - INDEX_LSB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  // Word address of slot cnt within the line whose upper address bits are line_addr
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [LINE_ADDR_WIDTH-1:0] line_addr,
    input logic [CNT_WIDTH-1:0]       cnt
  );
    return {line_addr, cnt, 2'b00};
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Miss, memory and line-delivery signals between the refill unit and its
// neighbours; slave is the refill unit, master is the cache/memory side.
interface icache_refill_if #(
  parameter int unsigned LINE_WIDTH = icache_refill_pkg::LINE_WIDTH
);

  logic                  miss_valid;
  logic [31:0]           miss_pc;
  logic                  miss_ready;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  line_valid;
  logic [LINE_WIDTH-1:0] line_data;
  logic [31:0]           line_pc;
  logic                  err;

  modport slave (
    input  miss_valid, miss_pc, mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, mem_req, mem_addr, line_valid, line_data, line_pc, err
  );

  modport master (
    output miss_valid, miss_pc, mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, mem_req, mem_addr, line_valid, line_data, line_pc, err
  );

endinterface

// File: rtl/icache_refill_timer.sv
// Loadable saturating counter measuring how long a memory response is outstanding.
module refill_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic last_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;

  // Saturates at LIMIT so a stuck tick can never wrap back to a safe value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (tick && (count_q != CW'(LIMIT))) begin
      count_q <= count_q + CW'(1);
    end
  end

  // The next tick brings the count to LIMIT
  assign last_c = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/icache_refill.sv
// Fetches one cache line as four sequential word reads from instruction memory
// and delivers it with a one-cycle line_valid pulse, aborting on response timeout.
module icache_refill #(
  parameter int unsigned LINE_WIDTH = icache_refill_pkg::LINE_WIDTH,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic            clk,
  input logic            rst,
  icache_refill_if.slave bus
);

  import icache_refill_pkg::*;

  refill_state_e          state_q, state_n;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_n;
  logic [31:0]            line_pc_q, line_pc_n;
  logic [LINE_WIDTH-1:0]  line_data_q, line_data_n;
  logic [31:0]            mem_addr_q, mem_addr_n;
  logic                   mem_req_q, mem_req_n;
  logic                   miss_ready_q, miss_ready_n;
  logic                   line_valid_q, line_valid_n;
  logic                   err_q, err_n;
  logic                   timer_clear_c;
  logic                   timer_tick_c;
  logic                   timer_last_c;

  refill_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_c),
    .tick   (timer_tick_c),
    .last_c (timer_last_c)
  );

  // State, fill context and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_pc_q    <= '0;
      line_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      miss_ready_q <= 1'b1;
      line_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      line_pc_q    <= line_pc_n;
      line_data_q  <= line_data_n;
      mem_addr_q   <= mem_addr_n;
      mem_req_q    <= mem_req_n;
      miss_ready_q <= miss_ready_n;
      line_valid_q <= line_valid_n;
      err_q        <= err_n;
    end
  end

  // Next-state, slot write and next-output decode
  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    line_pc_n     = line_pc_q;
    line_data_n   = line_data_q;
    timer_clear_c = 1'b0;
    timer_tick_c  = 1'b0;
    err_n         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.miss_valid) begin
          line_pc_n     = bus.miss_pc;
          cnt_n         = '0;
          timer_clear_c = 1'b1;
          state_n       = ST_REQ;
        end
      end
      ST_REQ: begin
        // A same-cycle rvalid is not a response to this request and is dropped
        if (bus.mem_gnt) begin
          timer_clear_c = 1'b1;
          state_n       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
              line_data_n[LINE_WIDTH-1-WORD_WIDTH*k -: WORD_WIDTH] = bus.mem_rdata;
            end
          end
          if (cnt_q == CNT_WIDTH'(WORDS_PER_LINE - 1)) begin
            state_n = ST_DONE;
          end else begin
            cnt_n   = cnt_q + CNT_WIDTH'(1);
            state_n = ST_REQ;
          end
        end else begin
          timer_tick_c = 1'b1;
          if (timer_last_c) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    miss_ready_n = (state_n == ST_IDLE);
    mem_req_n    = (state_n == ST_REQ);
    line_valid_n = (state_n == ST_DONE);
    mem_addr_n   = word_addr(line_pc_n[ADDR_WIDTH-1:INDEX_LSB], cnt_n);
  end

  assign bus.miss_ready = miss_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.line_valid = line_valid_q;
  assign bus.line_data  = line_data_q;
  assign bus.line_pc    = line_pc_q;
  assign bus.err        = err_q;

endmodule
